// File: rtl/dataflow_rx_pkg.sv
// Shared definitions for the serial receiver, its transmitter counterpart and benches.
//   rx_state_e   : receiver FSM states
//   PARITY_EVEN / PARITY_ODD : encodings of parity_type_even_odd
//   parity_bit() : expected parity bit from the XOR of the data bits
package dataflow_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Even parity sends the data XOR unchanged; odd parity inverts it.
    function automatic logic parity_bit(input logic data_xor, input logic ptype);
        return data_xor ^ (ptype == PARITY_ODD);
    endfunction

endpackage

// File: rtl/dataflow_rx.sv
// Serial frame receiver, one bit per clk, no oversampling.
// Frame: start 0, n data bits LSB first, optional parity, stop 1.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   Rx                    : serial line, idles high
//   parity_check          : 1 = frame carries a parity bit (latched at start)
//   parity_type_even_odd  : 0 = even, 1 = odd (latched at start)
//   Q                     : last received data word
//   valid                 : one-cycle pulse when a frame completes
//   parity_error          : pulse with valid on parity mismatch
//   frame_error           : pulse with valid when the stop bit is 0
//   busy                  : high whenever the FSM is not IDLE
module dataflow_rx
    import dataflow_rx_pkg::*;
#(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Rx,
    input  logic         parity_check,
    input  logic         parity_type_even_odd,
    output logic [n-1:0] Q,
    output logic         valid,
    output logic         parity_error,
    output logic         frame_error,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(n + 1);

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [n-1:0]       shift_q, shift_d;
    logic               par_q, par_d;
    logic               pflag_q, pflag_d;
    logic               pchk_q, pchk_d;
    logic               ptype_q, ptype_d;
    logic [n-1:0]       q_q, q_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               busy_q, busy_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!Rx) state_d = DATA;
            DATA:    if (cnt_q == CNT_W'(n - 1)) state_d = pchk_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            STOP:    state_d = Rx ? IDLE : BREAK;
            BREAK:   if (Rx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        pflag_d = pflag_q;
        pchk_d  = pchk_q;
        ptype_d = ptype_q;
        q_d     = q_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (!Rx) begin
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    pflag_d = 1'b0;
                    pchk_d  = parity_check;
                    ptype_d = parity_type_even_odd;
                end
            end
            DATA: begin
                for (int i = 0; i < int'(n); i++) begin
                    if (cnt_q == CNT_W'(i)) shift_d[i] = Rx;
                end
                par_d = par_q ^ Rx;
                // Saturate so the counter cannot wrap within a frame.
                if (cnt_q != CNT_W'(n)) cnt_d = cnt_q + CNT_W'(1);
            end
            PARITY: begin
                if (Rx != parity_bit(par_q, ptype_q)) pflag_d = 1'b1;
            end
            STOP: begin
                valid_d = 1'b1;
                q_d     = shift_q;
                perr_d  = pflag_q & pchk_q;
                ferr_d  = ~Rx;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pflag_q <= 1'b0;
            pchk_q  <= 1'b0;
            ptype_q <= 1'b0;
            q_q     <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pflag_q <= pflag_d;
            pchk_q  <= pchk_d;
            ptype_q <= ptype_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign Q            = q_q;
    assign valid        = valid_q;
    assign parity_error = perr_q;
    assign frame_error  = ferr_q;
    assign busy         = busy_q;

endmodule
